// File: rtl/mem_test_seq.sv
// Memory-traffic sequencer: pattern write pass and/or read-back verify pass over an address window.
// Latency: start sampled -> go next cycle; memValid sampled -> go drops next cycle; >=2 cycles per word.
// Backpressure: holds each request until memValid, waits for memValid low before the next; MEM_TEST_LFSR_EN selects the LFSR pattern.
module mem_test_seq #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 64,
    parameter int NUM_WORDS = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       seed,
    output logic [ADDR_W-1:0] address,
    output logic              w_rn,
    output logic              go,
    output logic [DATA_W-1:0] data_to_write,
    input  logic              memValid,
    input  logic [DATA_W-1:0] data_to_read,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef MEM_TEST_LFSR_EN
    localparam int GEN_W = DATA_W;
`else
    localparam int GEN_W = 16;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    // Pattern generator: the incrementing form keeps only the 16-bit seed+i word.
    function automatic logic [GEN_W-1:0] gen_load(input logic [15:0] s);
`ifdef MEM_TEST_LFSR_EN
        logic [GEN_W-1:0] v;
        v = {(DATA_W/16){s}};
        if (v == '0) begin
            v = GEN_W'(1);
        end
        return v;
`else
        return s;
`endif
    endfunction

    function automatic logic [GEN_W-1:0] gen_step(input logic [GEN_W-1:0] g);
`ifdef MEM_TEST_LFSR_EN
        return {g[GEN_W-2:0], g[DATA_W-1] ^ g[DATA_W-2] ^ g[DATA_W-4] ^ g[DATA_W-5]};
`else
        return g + 16'd1;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] gen_expand(input logic [GEN_W-1:0] g);
`ifdef MEM_TEST_LFSR_EN
        return g;
`else
        return {(DATA_W/16){g}};
`endif
    endfunction

    state_t              r_state;
    state_t              w_nxt_state;
    logic [ADDR_W-1:0]   r_base;
    logic [15:0]         r_seed;
    logic                r_verify;
    logic [IDX_W-1:0]    r_idx;
    logic [GEN_W-1:0]    r_gen;
    logic [TC_W-1:0]     r_tcnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wrn;
    logic                r_go;
    logic [DATA_W-1:0]   r_dat;
    logic                r_busy;
    logic                r_done;
    logic [15:0]         r_err;
    logic [ADDR_W-1:0]   r_ferr;
    logic                r_to;

    logic                w_load;
    logic [IDX_W-1:0]    w_nxt_idx;
    logic [GEN_W-1:0]    w_nxt_gen;
    logic [TC_W-1:0]     w_nxt_tcnt;
    logic                w_nxt_wrn;
    logic [15:0]         w_nxt_err;
    logic [ADDR_W-1:0]   w_nxt_ferr;
    logic                w_nxt_to;
    logic                w_nxt_done;
    logic [ADDR_W-1:0]   w_nxt_base;
    logic [ADDR_W-1:0]   w_nxt_addr;
    logic                w_nxt_req;
    logic                w_nxt_busy;
    logic                w_mismatch;

    assign address        = r_addr;
    assign w_rn           = r_wrn;
    assign go             = r_go;
    assign data_to_write  = r_dat;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_count      = r_err;
    assign first_err_addr = r_ferr;
    assign timeout        = r_to;

    // r_dat holds pattern(i) for the whole request, so reads compare against it directly.
    assign w_mismatch = (data_to_read != r_dat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_nxt_idx   = r_idx;
        w_nxt_gen   = r_gen;
        w_nxt_tcnt  = r_tcnt;
        w_nxt_wrn   = r_wrn;
        w_nxt_err   = r_err;
        w_nxt_ferr  = r_ferr;
        w_nxt_to    = r_to;
        w_nxt_done  = r_done;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_nxt_idx  = '0;
                    w_nxt_gen  = gen_load(seed);
                    w_nxt_tcnt = '0;
                    w_nxt_err  = '0;
                    w_nxt_ferr = '0;
                    w_nxt_to   = 1'b0;
                    w_nxt_done = 1'b0;
                    if (mode == 2'd1) begin
                        w_nxt_state = S_RD_REQ;
                        w_nxt_wrn   = 1'b0;
                    end else begin
                        w_nxt_state = S_WR_REQ;
                        w_nxt_wrn   = 1'b1;
                    end
                end
            end

            S_WR_REQ, S_RD_REQ: begin
                if (memValid) begin
                    w_nxt_state = (r_state == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
                    if ((r_state == S_RD_REQ) && w_mismatch) begin
                        if (r_err != 16'hFFFF) begin
                            w_nxt_err = r_err + 16'd1;
                        end
                        if (r_err == 16'd0) begin
                            w_nxt_ferr = r_addr;
                        end
                    end
                end else if (r_tcnt == TC_LAST) begin
                    w_nxt_to    = 1'b1;
                    w_nxt_state = S_FINISH;
                end else begin
                    w_nxt_tcnt = r_tcnt + TC_W'(1);
                end
            end

            S_WR_GAP, S_RD_GAP: begin
                if (!memValid) begin
                    w_nxt_tcnt = '0;
                    if (r_idx == LAST_IDX) begin
                        if ((r_state == S_WR_GAP) && r_verify) begin
                            w_nxt_state = S_RD_REQ;
                            w_nxt_idx   = '0;
                            w_nxt_gen   = gen_load(r_seed);
                            w_nxt_wrn   = 1'b0;
                        end else begin
                            w_nxt_state = S_FINISH;
                        end
                    end else begin
                        w_nxt_idx   = r_idx + IDX_W'(1);
                        w_nxt_gen   = gen_step(r_gen);
                        w_nxt_state = (r_state == S_WR_GAP) ? S_WR_REQ : S_RD_REQ;
                    end
                end
            end

            S_FINISH: begin
                w_nxt_state = S_IDLE;
            end

            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (w_nxt_state == S_FINISH) begin
            w_nxt_done = 1'b1;
        end
    end

    assign w_nxt_base = w_load ? base_addr : r_base;
    assign w_nxt_addr = w_nxt_base + ADDR_W'(w_nxt_idx);
    assign w_nxt_req  = (w_nxt_state == S_WR_REQ) || (w_nxt_state == S_RD_REQ);
    assign w_nxt_busy = w_nxt_req || (w_nxt_state == S_WR_GAP) || (w_nxt_state == S_RD_GAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base   <= '0;
            r_seed   <= '0;
            r_verify <= 1'b0;
            r_idx    <= '0;
            r_gen    <= '0;
            r_tcnt   <= '0;
            r_addr   <= '0;
            r_wrn    <= 1'b0;
            r_go     <= 1'b0;
            r_dat    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= '0;
            r_ferr   <= '0;
            r_to     <= 1'b0;
        end else begin
            if (w_load) begin
                r_base   <= base_addr;
                r_seed   <= seed;
                r_verify <= mode[1];
            end
            r_idx  <= w_nxt_idx;
            r_gen  <= w_nxt_gen;
            r_tcnt <= w_nxt_tcnt;
            r_wrn  <= w_nxt_wrn;
            r_err  <= w_nxt_err;
            r_ferr <= w_nxt_ferr;
            r_to   <= w_nxt_to;
            r_done <= w_nxt_done;
            r_go   <= w_nxt_req;
            r_busy <= w_nxt_busy;
            // Address and data only move on entry to a request so they stay stable while go is high.
            if (w_nxt_req) begin
                r_addr <= w_nxt_addr;
                r_dat  <= gen_expand(w_nxt_gen);
            end
        end
    end

endmodule

// File: tb/tb_mem_test_seq.sv
// Bench for mem_test_seq: behavioural SDRAM model with a request scoreboard, run in all modes.
module tb_mem_test_seq;

    localparam int AW  = 13;
    localparam int DW  = 64;
    localparam int LAT = 3;

    typedef struct packed {
        logic          wrn;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   seed = '0;
    logic [AW-1:0] address;
    logic          w_rn;
    logic          go;
    logic [DW-1:0] data_to_write;
    logic          memValid;
    logic [DW-1:0] data_to_read;
    logic          busy;
    logic          done;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic          timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;
    int never_resp = 0;
    int hold_extra = 0;
    int corrupt_a  = -1;
    int corrupt_b  = -1;

    txn_t          exp_q[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];

    mem_test_seq #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .seed(seed), .address(address), .w_rn(w_rn), .go(go),
        .data_to_write(data_to_write), .memValid(memValid), .data_to_read(data_to_read),
        .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [15:0] s, input int i);
        logic [15:0] v;
        v = s + 16'(i);
        return {4{v}};
    endfunction

    // Memory model: accepts a request while go is high, pulses memValid LAT cycles later
    // (optionally holding it high for hold_extra more cycles) and checks each request against exp_q.
    initial begin
        txn_t          o;
        txn_t          e;
        logic          m_busy;
        int            m_cnt;
        logic [DW-1:0] v;
        memValid     = 1'b0;
        data_to_read = '0;
        m_busy       = 1'b0;
        m_cnt        = 0;
        o            = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                memValid = 1'b0;
                m_busy   = 1'b0;
                m_cnt    = 0;
            end else if (m_busy) begin
                if (never_resp != 0) begin
                    if (!go) m_busy = 1'b0;
                end else begin
                    if (m_cnt >= LAT && go) viol++;
                    m_cnt++;
                    if (m_cnt == LAT) begin
                        memValid = 1'b1;
                        if (o.wrn) begin
                            mem[o.addr] = o.dat;
                        end else begin
                            v = mem[o.addr];
                            if (int'(o.addr) == corrupt_a || int'(o.addr) == corrupt_b) v = v ^ 64'd1;
                            data_to_read = v;
                        end
                    end else if (m_cnt > LAT + hold_extra) begin
                        memValid = 1'b0;
                        m_busy   = 1'b0;
                    end
                end
            end else if (go) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                o.wrn  = w_rn;
                o.addr = address;
                o.dat  = data_to_write;
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got request %h, expected none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) $display("FAIL sb_txn: got %h, expected %h", o, e);
                    else n_pass++;
                end
            end
        end
    end

    task automatic push_pass(input logic wrn, input logic [AW-1:0] base, input logic [15:0] s);
        txn_t t;
        for (int i = 0; i < 16; i++) begin
            t.wrn  = wrn;
            t.addr = base + AW'(i);
            t.dat  = pat(s, i);
            exp_q.push_back(t);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [AW-1:0] b, input logic [15:0] s);
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = b; seed = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 3000; k++) begin
            if (done) break;
            @(negedge clk);
        end
        n_chk++;
        if (done !== 1'b1) $display("FAIL %s: done=%b after cycle budget, required 1", name, done);
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_chk++; if (go !== 1'b0) $display("FAIL rst_go: got %b want 0", go); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_chk++; if (w_rn !== 1'b0) $display("FAIL rst_wrn: got %b want 0", w_rn); else n_pass++;
        n_chk++; if (address !== '0) $display("FAIL rst_addr: got %h want 0", address); else n_pass++;
        n_chk++; if (data_to_write !== '0) $display("FAIL rst_data: got %h want 0", data_to_write); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL rst_err: got %h want 0", err_count); else n_pass++;
        n_chk++; if (first_err_addr !== '0) $display("FAIL rst_ferr: got %h want 0", first_err_addr); else n_pass++;
        n_chk++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode2_ideal;
        push_pass(1'b1, 13'h0000, 16'h1234);
        push_pass(1'b0, 13'h0000, 16'h1234);
        start_run(2'd2, 13'h0000, 16'h1234);
        n_chk++; if (go !== 1'b1) $display("FAIL m2_go_latency: got %b want 1", go); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL m2_busy: got %b want 1", busy); else n_pass++;
        wait_done("m2_done");
        n_chk++; if (exp_q.size() != 0) $display("FAIL m2_sb_left: got %0d pending, want 0", exp_q.size()); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL m2_err: got %0d want 0", err_count); else n_pass++;
        n_chk++; if (timeout !== 1'b0) $display("FAIL m2_timeout: got %b want 0", timeout); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL m2_busy_end: got %b want 0", busy); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_corrupt;
        corrupt_a = 5;
        corrupt_b = 9;
        push_pass(1'b1, 13'h0000, 16'hA000);
        push_pass(1'b0, 13'h0000, 16'hA000);
        start_run(2'd2, 13'h0000, 16'hA000);
        n_chk++; if (done !== 1'b0) $display("FAIL cor_done_clear: got %b want 0", done); else n_pass++;
        wait_done("cor_done");
        n_chk++; if (err_count !== 16'd2) $display("FAIL cor_err: got %0d want 2", err_count); else n_pass++;
        n_chk++; if (first_err_addr !== 13'd5) $display("FAIL cor_first: got %h want 5", first_err_addr); else n_pass++;
        n_chk++; if (exp_q.size() != 0) $display("FAIL cor_sb_left: got %0d pending, want 0", exp_q.size()); else n_pass++;
        corrupt_a = -1;
        corrupt_b = -1;
        exp_q.delete();
    endtask

    task automatic test_wrap;
        push_pass(1'b1, 13'h1FFE, 16'hFFFE);
        start_run(2'd0, 13'h1FFE, 16'hFFFE);
        n_chk++; if (address !== 13'h1FFE) $display("FAIL wrap_first_addr: got %h want 1ffe", address); else n_pass++;
        wait_done("wrap_done");
        n_chk++; if (exp_q.size() != 0) $display("FAIL wrap_sb_left: got %0d pending, want 0", exp_q.size()); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL wrap_err: got %0d want 0", err_count); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_timeout;
        txn_t t;
        int   cnt;
        never_resp = 1;
        t.wrn  = 1'b1;
        t.addr = 13'h0300;
        t.dat  = pat(16'h0001, 0);
        exp_q.push_back(t);
        start_run(2'd0, 13'h0300, 16'h0001);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!go) break;
            cnt++;
            @(negedge clk);
        end
        n_chk++; if (cnt != 8) $display("FAIL to_go_cycles: got %0d want 8", cnt); else n_pass++;
        n_chk++; if (timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout); else n_pass++;
        n_chk++; if (done !== 1'b1) $display("FAIL to_done: got %b want 1", done); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (exp_q.size() != 0) $display("FAIL to_sb_left: got %0d pending, want 0", exp_q.size()); else n_pass++;
        repeat (2) @(negedge clk);
        never_resp = 0;
        exp_q.delete();
    endtask

    task automatic test_reset_midrun;
        int reached;
        corrupt_a = 'h103;
        push_pass(1'b1, 13'h0100, 16'h0F00);
        push_pass(1'b0, 13'h0100, 16'h0F00);
        start_run(2'd2, 13'h0100, 16'h0F00);
        reached = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!w_rn && go && exp_q.size() <= 10) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        n_chk++; if (reached != 1) $display("FAIL mid_reach_read: got %0d want 1", reached); else n_pass++;
        n_chk++; if (err_count !== 16'd1) $display("FAIL mid_err_before: got %0d want 1", err_count); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (go !== 1'b0) $display("FAIL mid_go_async: got %b want 0", go); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL mid_err_rst: got %0d want 0", err_count); else n_pass++;
        n_chk++; if (address !== '0) $display("FAIL mid_addr: got %h want 0", address); else n_pass++;
        n_chk++; if (first_err_addr !== '0) $display("FAIL mid_ferr: got %h want 0", first_err_addr); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        corrupt_a = -1;
        exp_q.delete();
        @(negedge clk);
        push_pass(1'b0, 13'h0100, 16'h0F00);
        start_run(2'd1, 13'h0100, 16'h0F00);
        n_chk++; if (w_rn !== 1'b0 || go !== 1'b1) $display("FAIL m1_first_req: got w_rn=%b go=%b want 0/1", w_rn, go); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL m1_err_start: got %0d want 0", err_count); else n_pass++;
        wait_done("m1_done");
        n_chk++; if (err_count !== 16'd0) $display("FAIL m1_err: got %0d want 0", err_count); else n_pass++;
        n_chk++; if (exp_q.size() != 0) $display("FAIL m1_sb_left: got %0d pending, want 0", exp_q.size()); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        hold_extra = 3;
        push_pass(1'b1, 13'h0040, 16'h5555);
        start_run(2'd0, 13'h0040, 16'h5555);
        for (int k = 0; k < 4; k++) begin
            repeat (7) @(negedge clk);
            start = 1'b1; mode = 2'd1; base_addr = 13'h0007;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("b2b_done");
        n_chk++; if (exp_q.size() != 0) $display("FAIL b2b_sb_left: got %0d pending, want 0", exp_q.size()); else n_pass++;
        n_chk++; if (viol != 0) $display("FAIL b2b_go_during_valid: got %0d violations, want 0", viol); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || go !== 1'b0) $display("FAIL b2b_no_restart: got busy=%b go=%b want 0/0", busy, go); else n_pass++;
        n_chk++; if (done !== 1'b1) $display("FAIL b2b_done_hold: got %b want 1", done); else n_pass++;
        hold_extra = 0;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_mode2_ideal();
        test_corrupt();
        test_wrap();
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required run completion");
        $fatal(1, "watchdog");
    end

endmodule
